// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO architectural register pair with an iterative divider.
//
// Holds the HI/LO registers written from WB. Runs DIV/DIVU as a restoring
// divider, one quotient bit per cycle, and writes HI=remainder,
// LO=quotient when the divide finishes.
//
// Optional feature macro: HILO_FWD_EN
//   defined   - hi_o/lo_o forward, per half: MEM pending > WB write >
//               divider FIN result > stored register.
//   undefined - hi_o/lo_o show the stored registers only.
//
// Ports
//   clk_i          clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   wb_we_i        WB write enables {hi, lo}
//   wb_wdata_i     WB write data {hi, lo}
//   mem_we_i       MEM-stage pending write enables {hi, lo} (forwarding only)
//   mem_wdata_i    MEM-stage pending data {hi, lo}
//   div_start_i    start a divide (sampled in IDLE only)
//   div_signed_i   1 = DIV, 0 = DIVU
//   div_dividend_i dividend, captured at start
//   div_divisor_i  divisor, captured at start
//   div_annul_i    abort the divide in progress
//   div_busy_o     divider not IDLE
//   div_done_o     one-cycle pulse in FIN when the result is written
//   hi_o, lo_o     HI/LO operands to the ALU
//
// State  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no divide running; accepts div_start_i
// S_CALC | one restoring-division step per cycle, DATA_W steps total
// S_FIN  | sign fix-up; HI/LO written at the exit edge unless annulled

module hilo_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [1:0]            wb_we_i,
   input  logic [2*DATA_W-1:0]   wb_wdata_i,
   input  logic [1:0]            mem_we_i,
   input  logic [2*DATA_W-1:0]   mem_wdata_i,
   input  logic                  div_start_i,
   input  logic                  div_signed_i,
   input  logic [DATA_W-1:0]     div_dividend_i,
   input  logic [DATA_W-1:0]     div_divisor_i,
   input  logic                  div_annul_i,
   output logic                  div_busy_o,
   output logic                  div_done_o,
   output logic [DATA_W-1:0]     hi_o,
   output logic [DATA_W-1:0]     lo_o
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

   state_t              state_q, state_d;
   logic                start_ok;
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   rem_q, quo_q, dvs_q;
   logic                sgn_a_q, sgn_b_q, signed_q, dz_q;
   logic [DATA_W-1:0]   hi_q, lo_q;

   logic                a_neg, b_neg, div_zero;
   logic [DATA_W-1:0]   a_abs, b_abs;
   logic [DATA_W:0]     shifted, trial;
   logic                ge;
   logic [DATA_W-1:0]   q_fix, r_fix;
   logic                div_wr;

   // ---------------- FSM ----------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      start_ok   = 1'b0;
      div_busy_o = (state_q != S_IDLE);
      div_done_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (div_start_i) begin
               start_ok = 1'b1;
               state_d  = div_zero ? S_FIN : S_CALC;
            end
         end
         S_CALC: begin
            if (div_annul_i)     state_d = S_IDLE;
            else if (cnt_q == '0) state_d = S_FIN;
         end
         S_FIN: begin
            state_d    = S_IDLE;
            div_done_o = !div_annul_i;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- operand capture ----------------
   assign div_zero = (div_divisor_i == '0);
   assign a_neg    = div_signed_i & div_dividend_i[DATA_W-1];
   assign b_neg    = div_signed_i & div_divisor_i[DATA_W-1];
   assign a_abs    = a_neg ? -div_dividend_i : div_dividend_i;
   assign b_abs    = b_neg ? -div_divisor_i  : div_divisor_i;

   // quo_q starts as the dividend and shifts out MSB-first while quotient
   // bits shift in at the bottom; rem_q < dvs_q always, so the 33-bit
   // shifted value never needs more than one subtract.
   assign shifted = {rem_q, quo_q[DATA_W-1]};
   assign ge      = (shifted >= {1'b0, dvs_q});
   assign trial   = shifted - {1'b0, dvs_q};

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         sgn_a_q  <= 1'b0;
         sgn_b_q  <= 1'b0;
         signed_q <= 1'b0;
         dz_q     <= 1'b0;
      end else if (start_ok) begin
         cnt_q    <= CNT_W'(DATA_W-1);
         dvs_q    <= b_abs;
         sgn_a_q  <= a_neg;
         sgn_b_q  <= b_neg;
         signed_q <= div_signed_i;
         dz_q     <= div_zero;
         // Divide by zero skips CALC: preload the architectural result.
         rem_q    <= div_zero ? a_abs : '0;
         quo_q    <= div_zero ? '1    : a_abs;
      end else if (state_q == S_CALC && !div_annul_i) begin
         rem_q <= ge ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
         quo_q <= {quo_q[DATA_W-2:0], ge};
         if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
   end

   // ---------------- FIN sign fix-up ----------------
   assign q_fix  = (signed_q & (sgn_a_q ^ sgn_b_q) & !dz_q) ? -quo_q : quo_q;
   assign r_fix  = (signed_q & sgn_a_q) ? -rem_q : rem_q;
   assign div_wr = div_done_o;

   // ---------------- HI/LO registers ----------------
   // WB is the younger instruction, so it wins per half over the divider.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (wb_we_i[1])  hi_q <= wb_wdata_i[2*DATA_W-1:DATA_W];
         else if (div_wr) hi_q <= r_fix;
         if (wb_we_i[0])  lo_q <= wb_wdata_i[DATA_W-1:0];
         else if (div_wr) lo_q <= q_fix;
      end
   end

   // ---------------- operand outputs ----------------
`ifdef HILO_FWD_EN
   logic unused_bits;
   assign unused_bits = trial[DATA_W];

   always_comb begin
      if (mem_we_i[1])     hi_o = mem_wdata_i[2*DATA_W-1:DATA_W];
      else if (wb_we_i[1]) hi_o = wb_wdata_i[2*DATA_W-1:DATA_W];
      else if (div_wr)     hi_o = r_fix;
      else                 hi_o = hi_q;
      if (mem_we_i[0])     lo_o = mem_wdata_i[DATA_W-1:0];
      else if (wb_we_i[0]) lo_o = wb_wdata_i[DATA_W-1:0];
      else if (div_wr)     lo_o = q_fix;
      else                 lo_o = lo_q;
   end
`else
   logic unused_bits;
   assign unused_bits = ^{trial[DATA_W], mem_we_i, mem_wdata_i};

   assign hi_o = hi_q;
   assign lo_o = lo_q;
`endif

endmodule
